// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the core and the RV32M multiply/divide unit.
// The core drives the master side and the unit drives the slave side.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Operands are latched as magnitudes at issue, WIDTH unsigned iterations run
// in CALC (shift-add multiply or restoring divide), and the sign fix-up is
// folded into the result register on the edge that enters DONE.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  muldiv_unit_if.slave       bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       f3_q;
  logic             neg_a_q, neg_b_q;   // operand negative AND treated as signed
  logic             div0_q;
  logic [WIDTH-1:0] dsr_q;              // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0] hi_q, hi_d;         // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;         // multiplier->product low / dividend->quotient
  logic [WIDTH-1:0] result_q, result_d;

  logic accept;
  logic last_iter;

  // A start is only honoured outside CALC, so a busy unit ignores it entirely.
  assign accept    = bus.start && (state_q != S_CALC);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // Operand preparation at acceptance
  // ---------------------------------------------------------------------------
  logic             in_is_div;
  logic             in_a_signed, in_b_signed;
  logic             in_neg_a, in_neg_b;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;

  // Decode signedness of each operand and take magnitudes of negative ones.
  // MUL's low half is sign-agnostic, so treating it as signed x signed is safe.
  always_comb begin
    in_is_div   = bus.funct3[2];
    in_a_signed = 1'b0;
    in_b_signed = 1'b0;
    if (in_is_div) begin
      in_a_signed = ~bus.funct3[0];
      in_b_signed = ~bus.funct3[0];
    end else begin
      in_a_signed = (bus.funct3[1:0] != 2'b11);
      in_b_signed = ~bus.funct3[1];
    end
    in_neg_a = in_a_signed & bus.op_a[WIDTH-1];
    in_neg_b = in_b_signed & bus.op_b[WIDTH-1];
    in_mag_a = in_neg_a ? (~bus.op_a + 1'b1) : bus.op_a;
    in_mag_b = in_neg_b ? (~bus.op_b + 1'b1) : bus.op_b;
  end

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_trial;

  // Multiply: add multiplicand to the high half when the current multiplier bit
  // is set, then shift {carry, hi, lo} right by one.
  // Divide: shift the next dividend bit into the remainder and keep the
  // subtraction only if it does not go negative.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dsr_q} : {(WIDTH+1){1'b0}});
    div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, dsr_q};
    if (f3_q[2]) begin
      if (!div_trial[WIDTH]) begin
        hi_d = div_trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Final sign correction and result selection
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_u, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  // Evaluated on the last CALC cycle from the post-iteration values, so the
  // result lands in the same edge that enters DONE. Divide-by-zero needs only
  // the quotient forced: the remainder naturally comes out as op_a. Signed
  // overflow falls out of the magnitude arithmetic without special handling.
  always_comb begin
    prod_u   = {hi_d, lo_d};
    prod_s   = (neg_a_q ^ neg_b_q) ? (~prod_u + 1'b1) : prod_u;
    quo_s    = (neg_a_q ^ neg_b_q) ? (~lo_d + 1'b1) : lo_d;
    rem_s    = neg_a_q ? (~hi_d + 1'b1) : hi_d;
    result_d = result_q;
    if (f3_q[2]) begin
      if (f3_q[1])     result_d = rem_s;
      else if (div0_q) result_d = {WIDTH{1'b1}};
      else             result_d = quo_s;
    end else begin
      if (f3_q[1:0] == 2'b00) result_d = prod_s[WIDTH-1:0];
      else                    result_d = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // IDLE/DONE accept a new operation; CALC runs exactly WIDTH iterations.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_CALC;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        if (last_iter) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (accept) begin
          state_d = S_CALC;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register and iteration counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand latch at acceptance, then one iteration per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div0_q  <= 1'b0;
      dsr_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (accept) begin
      f3_q    <= bus.funct3;
      neg_a_q <= in_neg_a;
      neg_b_q <= in_neg_b;
      div0_q  <= (bus.op_b == '0);
      hi_q    <= '0;
      if (in_is_div) begin
        dsr_q <= in_mag_b;
        lo_q  <= in_mag_a;
      end else begin
        dsr_q <= in_mag_a;
        lo_q  <= in_mag_b;
      end
    end else if (state_q == S_CALC) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Result only changes on the edge entering DONE and holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else if ((state_q == S_CALC) && last_iter) begin
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == S_CALC);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, arithmetic, special cases,
// handshake behaviour and reset.
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  muldiv_unit_if #(.WIDTH(32)) bus();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation (start high for one cycle) and observe cycles 1..34.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int done_cyc, output int done_cnt, output int busy_cnt,
                       output int busy_bad, output logic [31:0] res);
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; busy_bad = 0; res = 'x;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (bus.busy) begin
        busy_cnt++;
        if (c > 32) busy_bad++;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          res = bus.result;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0;
    #2;
    tests++;
    if ({bus.busy, bus.done, bus.result} !== 34'd0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, expected all 0",
               bus.busy, bus.done, bus.result);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_mul();
    int dc, dn, bc, bb;
    logic [31:0] r;
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, dc, dn, bc, bb, r);
    tests++;
    if (dc !== 33 || dn !== 1) begin
      fails++; $display("FAIL mul_done_cycle: got cycle %0d count %0d, expected cycle 33 count 1", dc, dn);
    end
    tests++;
    if (r !== 32'hFFFF_FFEB) begin
      fails++; $display("FAIL mul_result: got %h expected ffffffeb", r);
    end
    tests++;
    if (bc !== 32 || bb !== 0) begin
      fails++; $display("FAIL mul_busy: got %0d busy cycles (%0d outside 1..32), expected 32", bc, bb);
    end
  endtask

  task automatic test_mulh();
    logic [2:0]  f  [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] a  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int dc, dn, bc, bb;
    logic [31:0] r;
    for (int i = 0; i < 3; i++) begin
      do_op(f[i], a[i], b[i], dc, dn, bc, bb, r);
      tests++;
      if (r !== ex[i] || dc !== 33) begin
        fails++;
        $display("FAIL mulh_%0d: got %h at cycle %0d, expected %h at cycle 33", i, r, dc, ex[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] a  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ex [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int dc, dn, bc, bb;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], b[i], dc, dn, bc, bb, r);
      tests++;
      if (r !== ex[i] || dc !== 33) begin
        fails++;
        $display("FAIL div_%0d: got %h at cycle %0d, expected %h at cycle 33", i, r, dc, ex[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f  [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] a  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int dc, dn, bc, bb;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], b[i], dc, dn, bc, bb, r);
      tests++;
      if (r !== ex[i] || dc !== 33 || bc !== 32) begin
        fails++;
        $display("FAIL special_%0d: got %h at cycle %0d busy %0d, expected %h at cycle 33 busy 32",
                 i, r, dc, bc, ex[i]);
      end
    end
  endtask

  // op_a changes in cycle 5 and a second start arrives in cycle 10: both ignored.
  task automatic test_handshake();
    int dc = -1;
    int dn = 0;
    logic [31:0] r = 'x;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd6; bus.op_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      if (c == 5) bus.op_a = 32'd1000;
      if (c == 10) begin
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd100; bus.op_b = 32'd7;
      end
      if (c == 11) bus.start = 1'b0;
      @(negedge clk);
      if (bus.done) begin
        dn++;
        if (dc < 0) begin dc = c; r = bus.result; end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (dc !== 33 || dn !== 1) begin
      fails++; $display("FAIL hs_timing: got done cycle %0d count %0d, expected 33 and 1", dc, dn);
    end
    tests++;
    if (r !== 32'd42) begin
      fails++; $display("FAIL hs_result: got %h expected 0000002a", r);
    end
  endtask

  // Second start held during the DONE cycle of the first.
  task automatic test_back_to_back();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd6; bus.op_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    tests++;
    if (bus.done !== 1'b1 || bus.result !== 32'd42) begin
      fails++; $display("FAIL b2b_first: got done=%b result=%h, expected 1 and 0000002a", bus.done, bus.result);
    end
    bus.start = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      fails++; $display("FAIL b2b_restart: got busy=%b done=%b, expected 1 0", bus.busy, bus.done);
    end
    repeat (31) @(posedge clk);
    #1;
    tests++;
    if (bus.done !== 1'b0 || bus.result !== 32'd42) begin
      fails++; $display("FAIL b2b_cycle32: got done=%b result=%h, expected 0 and 0000002a", bus.done, bus.result);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.done !== 1'b1 || bus.result !== 32'd14) begin
      fails++; $display("FAIL b2b_second: got done=%b result=%h, expected 1 and 0000000e", bus.done, bus.result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int dc, dn, bc, bb;
    int late_done = 0;
    logic [31:0] r;
    do_op(3'b101, 32'd100, 32'd7, dc, dn, bc, bb, r);   // leaves result = 14
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'b100; bus.op_a = 32'hFFFF_FFF9; bus.op_b = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    tests++;
    if (bus.busy !== 1'b1 || bus.result !== 32'd14) begin
      fails++; $display("FAIL rst_pre: got busy=%b result=%h, expected 1 and 0000000e", bus.busy, bus.result);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.result} !== 34'd0) begin
      fails++; $display("FAIL rst_mid: busy=%b done=%b result=%h, expected all 0", bus.busy, bus.done, bus.result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) late_done++;
    end
    tests++;
    if (late_done !== 0) begin
      fails++; $display("FAIL rst_no_done: got %0d done cycles, expected 0", late_done);
    end
    do_op(3'b000, 32'd3, 32'd4, dc, dn, bc, bb, r);
    tests++;
    if (r !== 32'd12 || dc !== 33) begin
      fails++; $display("FAIL rst_after_mul: got %h at cycle %0d, expected 0000000c at cycle 33", r, dc);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
